// File: rtl/prescaler_sync_mux_if.sv
// Bus between the GTCCR/TCCRnB register side and the shared prescaler:
// control inputs, external pins, and the per-channel count enables it hands back.
interface prescaler_sync_mux_if #(
  parameter int NCH   = 2,
  parameter int WIDTH = 10
);
  logic                 psr_wr;
  logic                 tsm;
  logic [3*NCH-1:0]     cs;
  logic [NCH-1:0]       tpin;
  logic [NCH-1:0]       cnt_en;
  logic                 psr_flag;
  logic [WIDTH-1:0]     prescale_cnt;

  modport master (
    output psr_wr, tsm, cs, tpin,
    input  cnt_en, psr_flag, prescale_cnt
  );

  modport slave (
    input  psr_wr, tsm, cs, tpin,
    output cnt_en, psr_flag, prescale_cnt
  );
endinterface

// File: rtl/prescaler_sync_mux.sv
// Shared timer prescaler: one free-running divide counter, per-channel clock-select
// mux, prescaler reset with TSM hold, and synchronised external-pin edge detection.
module prescaler_sync_mux #(
  parameter int NCH   = 2,
  parameter int WIDTH = 10,
  parameter int TAP1  = 3,
  parameter int TAP2  = 6,
  parameter int TAP3  = 8,
  parameter int TAP4  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  prescaler_sync_mux_if.slave  bus
);

  logic [WIDTH-1:0] counter;
  logic             psr_hold;
  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   prev;
  logic [NCH-1:0]   rise;
  logic [NCH-1:0]   fall;
  logic             tap1;
  logic             tap2;
  logic             tap3;
  logic             tap4;
  logic [NCH-1:0]   en_sel;

  // A prescaler write clears the counter once; with TSM set it keeps it cleared until TSM drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter  <= '0;
      psr_hold <= 1'b0;
    end else begin
      if (bus.psr_wr | psr_hold)
        counter <= '0;
      else
        counter <= counter + WIDTH'(1);
      psr_hold <= bus.tsm & (bus.psr_wr | psr_hold);
    end
  end

  // Two-flop synchroniser on the raw pins, plus one more stage for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= bus.tpin;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
  assign fall = ~sync2 & prev;

  assign tap1 = &counter[TAP1-1:0];
  assign tap2 = &counter[TAP2-1:0];
  assign tap3 = &counter[TAP3-1:0];
  assign tap4 = &counter[TAP4-1:0];

  // Clock-select mux: combinational on CS so a change takes effect in the same cycle.
  always_comb begin
    en_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      case (bus.cs[3*i +: 3])
        3'b000:  en_sel[i] = 1'b0;
        3'b001:  en_sel[i] = ~psr_hold;
        3'b010:  en_sel[i] = tap1 & ~psr_hold;
        3'b011:  en_sel[i] = tap2 & ~psr_hold;
        3'b100:  en_sel[i] = tap3 & ~psr_hold;
        3'b101:  en_sel[i] = tap4 & ~psr_hold;
        3'b110:  en_sel[i] = fall[i];
        default: en_sel[i] = rise[i];
      endcase
    end
  end

  // Gating with reset makes the enables drop as soon as reset asserts, even for CS=001.
  assign bus.cnt_en       = reset ? en_sel : '0;
  assign bus.psr_flag     = psr_hold;
  assign bus.prescale_cnt = counter;

endmodule

// File: tb/tb_prescaler_sync_mux.sv
// Bench for prescaler_sync_mux: directed scenarios with literal checks plus a
// per-cycle comparison against an arithmetic model of the prescaler.
module tb_prescaler_sync_mux;

  localparam int NCH   = 2;
  localparam int WIDTH = 10;
  localparam int MODN  = 1 << WIDTH;

  logic clk;
  logic reset;

  int compareCount;
  int mismatchCount;

  int         mCnt;
  bit         mHold;
  logic [1:0] hist0;
  logic [1:0] hist1;
  logic [1:0] hist2;

  prescaler_sync_mux_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

  prescaler_sync_mux #(
    .NCH(NCH), .WIDTH(WIDTH), .TAP1(3), .TAP2(6), .TAP3(8), .TAP4(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model: counter as an integer modulo 2^WIDTH, pin history as the last three samples.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mCnt  = 0;
      mHold = 1'b0;
      hist0 = '0;
      hist1 = '0;
      hist2 = '0;
    end else begin
      hist2 = hist1;
      hist1 = hist0;
      hist0 = bus.tpin;
      if (bus.psr_wr || mHold) mCnt = 0;
      else                     mCnt = (mCnt + 1) % MODN;
      mHold = bus.tsm && (bus.psr_wr || mHold);
    end
  end

  function automatic logic [1:0] expEn();
    logic [1:0] e;
    e = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      case (bus.cs[3*ch +: 3])
        3'b001:  e[ch] = !mHold;
        3'b010:  e[ch] = (mCnt % 8    == 7)    && !mHold;
        3'b011:  e[ch] = (mCnt % 64   == 63)   && !mHold;
        3'b100:  e[ch] = (mCnt % 256  == 255)  && !mHold;
        3'b101:  e[ch] = (mCnt % 1024 == 1023) && !mHold;
        3'b110:  e[ch] = !hist1[ch] && hist2[ch];
        3'b111:  e[ch] = hist1[ch] && !hist2[ch];
        default: e[ch] = 1'b0;
      endcase
    end
    if (!reset) e = '0;
    return e;
  endfunction

  always @(negedge clk) begin
    checkOutput("model_cnt_en", 32'(bus.cnt_en), 32'(expEn()));
    checkOutput("model_prescale_cnt", 32'(bus.prescale_cnt), 32'(mCnt));
    checkOutput("model_psr_flag", 32'(bus.psr_flag), 32'(mHold));
  end

  task automatic applyStimulus(input logic psrWr, input logic tsmV, input logic [5:0] csV,
                               input logic [1:0] pinV, input int cycles);
    bus.psr_wr = psrWr;
    bus.tsm    = tsmV;
    bus.cs     = csV;
    bus.tpin   = pinV;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      bus.psr_wr = 1'b0;
    end
  endtask

  task automatic waitCnt(input int target);
    int n;
    n = 0;
    while (int'(bus.prescale_cnt) != target && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) checkOutput("wait_cnt_timeout", 32'(bus.prescale_cnt), 32'(target));
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    reset      = 1'b0;
    bus.psr_wr = 1'b0;
    bus.tsm    = 1'b0;
    bus.cs     = 6'b010_010;
    bus.tpin   = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cnt", 32'(bus.prescale_cnt), 32'd0);
    checkOutput("reset_en", 32'(bus.cnt_en), 32'd0);
    checkOutput("reset_flag", 32'(bus.psr_flag), 32'd0);
    reset = 1'b1;

    // T1: /8 on both channels, then /1024
    waitCnt(6);
    checkOutput("t1_no_pulse_at6", 32'(bus.cnt_en), 32'd0);
    waitCnt(7);
    checkOutput("t1_pulse_at7", 32'(bus.cnt_en), 32'b11);
    waitCnt(15);
    checkOutput("t1_pulse_at15", 32'(bus.cnt_en), 32'b11);
    bus.cs = 6'b101_101;
    waitCnt(1022);
    checkOutput("t1_no_pulse_at1022", 32'(bus.cnt_en), 32'd0);
    waitCnt(1023);
    checkOutput("t1_pulse_at1023", 32'(bus.cnt_en), 32'b11);

    // T2: lone prescaler write clears once, /64 restarts from zero
    bus.cs = 6'b000_011;
    waitCnt(40);
    applyStimulus(1'b1, 1'b0, 6'b000_011, 2'b00, 1);
    checkOutput("t2_cleared", 32'(bus.prescale_cnt), 32'd0);
    checkOutput("t2_flag", 32'(bus.psr_flag), 32'd0);
    applyStimulus(1'b0, 1'b0, 6'b000_011, 2'b00, 62);
    checkOutput("t2_cnt62", 32'(bus.prescale_cnt), 32'd62);
    checkOutput("t2_no_pulse_62", 32'(bus.cnt_en), 32'd0);
    applyStimulus(1'b0, 1'b0, 6'b000_011, 2'b00, 1);
    checkOutput("t2_pulse_63", 32'(bus.cnt_en), 32'b01);

    // T3: TSM hold with clk/1 select
    applyStimulus(1'b1, 1'b1, 6'b000_001, 2'b00, 1);
    checkOutput("t3_flag_set", 32'(bus.psr_flag), 32'd1);
    checkOutput("t3_cnt_held", 32'(bus.prescale_cnt), 32'd0);
    checkOutput("t3_en_off", 32'(bus.cnt_en), 32'd0);
    applyStimulus(1'b0, 1'b1, 6'b000_001, 2'b00, 50);
    applyStimulus(1'b1, 1'b1, 6'b000_001, 2'b00, 50);
    checkOutput("t3_cnt_still_held", 32'(bus.prescale_cnt), 32'd0);
    checkOutput("t3_en_still_off", 32'(bus.cnt_en), 32'd0);
    applyStimulus(1'b0, 1'b0, 6'b000_001, 2'b00, 1);
    checkOutput("t3_flag_clear", 32'(bus.psr_flag), 32'd0);
    checkOutput("t3_cnt_first", 32'(bus.prescale_cnt), 32'd0);
    checkOutput("t3_en_resume", 32'(bus.cnt_en), 32'b01);
    applyStimulus(1'b0, 1'b0, 6'b000_001, 2'b00, 1);
    checkOutput("t3_cnt_one", 32'(bus.prescale_cnt), 32'd1);

    // T4: ch0 on rising pin edges, ch1 on falling, pins toggled every 10 clocks
    for (int t = 0; t < 4; t++) begin
      logic [1:0] pin;
      pin = (t % 2 == 0) ? 2'b11 : 2'b00;
      applyStimulus(1'b0, 1'b0, 6'b110_111, pin, 1);
      checkOutput("t4_sync_delay", 32'(bus.cnt_en), 32'd0);
      applyStimulus(1'b0, 1'b0, 6'b110_111, pin, 1);
      checkOutput("t4_edge_pulse", 32'(bus.cnt_en), (t % 2 == 0) ? 32'b01 : 32'b10);
      applyStimulus(1'b0, 1'b0, 6'b110_111, pin, 1);
      checkOutput("t4_single_pulse", 32'(bus.cnt_en), 32'd0);
      applyStimulus(1'b0, 1'b0, 6'b110_111, pin, 7);
    end

    // T5: CS switched mid-count; ch1 stopped
    bus.cs = 6'b000_101;
    waitCnt(3);
    bus.cs = 6'b000_010;
    waitCnt(7);
    checkOutput("t5_early_tap_pulse", 32'(bus.cnt_en), 32'b01);

    // T6: reset mid-operation while a pin edge is in the synchroniser
    bus.cs = 6'b110_111;
    waitCnt(500);
    bus.tpin = 2'b11;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("t6_async_cnt", 32'(bus.prescale_cnt), 32'd0);
    checkOutput("t6_async_en", 32'(bus.cnt_en), 32'd0);
    checkOutput("t6_async_flag", 32'(bus.psr_flag), 32'd0);
    bus.tpin = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'b110_111, 2'b00, 1);
    checkOutput("t6_cnt_after_release", 32'(bus.prescale_cnt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 6'b110_111, 2'b00, 1);
      checkOutput("t6_no_spurious_ext", 32'(bus.cnt_en), 32'd0);
    end

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
